multi_cell_health_monitor: RTL and testbench

Per-cell battery supervisor for an N-cell pack. Each valid sample carries a level and a voltage for every cell. For each cell the block tracks a charge zone with hysteresis and emits one-cycle zone-entry pulses. It detects persistent overvoltage with a latched, acknowledgeable alert, and drives a single pack-wide charge enable. It sits between the cell ADC/fuel-gauge front end and the charger control logic, and generalises the single-cell health monitor to multiple cells.

---
 rtl/cell_mon_pkg.sv | 30 +++
 rtl/cell_zone_tracker.sv | 137 +++++++++++++
 rtl/multi_cell_health_monitor.sv | 115 +++++++++++
 tb/tb_multi_cell_health_monitor.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cell_mon_pkg.sv
// Shared definitions for the multi-cell health monitor.
//   zone_t   : charge zone of one cell, ordered LOW < MID < HEALTHY < FULL so
//              that "higher zone" comparisons follow the numeric encoding.
//   raw_zone : threshold-only classification of a level, without hysteresis.
package cell_mon_pkg;

  typedef enum logic [1:0] {
    ZONE_LOW     = 2'd0,
    ZONE_MID     = 2'd1,
    ZONE_HEALTHY = 2'd2,
    ZONE_FULL    = 2'd3
  } zone_t;

  // LOW wins over every other zone, then FULL (levels above FULL_LVL are
  // still FULL), then HEALTHY; everything in between is MID.
  function automatic zone_t raw_zone(input int unsigned lvl,
                                     input int unsigned low_lvl,
                                     input int unsigned healthy_lvl,
                                     input int unsigned full_lvl);
    if (lvl <= low_lvl)
      return ZONE_LOW;
    else if (lvl >= full_lvl)
      return ZONE_FULL;
    else if (lvl >= healthy_lvl)
      return ZONE_HEALTHY;
    else
      return ZONE_MID;
  endfunction

endpackage

// File: rtl/cell_zone_tracker.sv
// Per-cell supervisor: zone FSM with hysteresis, zone-entry pulses,
// persistent-overvoltage counter and the latched overcharge alert.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   sample_valid      : level/voltage valid this cycle
//   level, voltage    : this cell's sample
//   ack_fault         : request to clear the alert (honoured only when the
//                       overvoltage counter is already zero)
//   pulse_low/healthy/full : one-cycle zone-entry pulses (registered)
//   overcharge_alert  : latched alert (registered)
//   in_full           : cell currently in FULL, used for the pack enable
module cell_zone_tracker
  import cell_mon_pkg::*;
#(
  parameter int unsigned LVL_W       = 8,
  parameter int unsigned V_W         = 8,
  parameter int unsigned LOW_LVL     = 20,
  parameter int unsigned HEALTHY_LVL = 80,
  parameter int unsigned FULL_LVL    = 100,
  parameter int unsigned HYST        = 2,
  parameter int unsigned V_MAX       = 240,
  parameter int unsigned OV_PERSIST  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_valid,
  input  logic [LVL_W-1:0] level,
  input  logic [V_W-1:0]   voltage,
  input  logic             ack_fault,
  output logic             pulse_low,
  output logic             pulse_healthy,
  output logic             pulse_full,
  output logic             overcharge_alert,
  output logic             in_full
);

  localparam int unsigned CNT_W = $clog2(OV_PERSIST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OV_PERSIST);

  zone_t            zone_reg;
  zone_t            zone_next;
  zone_t            raw;
  logic             init_reg;
  logic             pulse_low_reg;
  logic             pulse_healthy_reg;
  logic             pulse_full_reg;
  logic [CNT_W-1:0] ov_cnt_reg;
  logic [CNT_W-1:0] ov_cnt_next;
  logic             alert_reg;
  logic             alert_set;
  logic             alert_clr;
  logic [31:0]      lvl32;

  assign lvl32 = 32'(level);
  assign raw   = raw_zone(lvl32, LOW_LVL, HEALTHY_LVL, FULL_LVL);

  // Zone transition with hysteresis. Upward moves are immediate except out
  // of LOW; allowed downward moves land directly on the raw zone.
  always_comb begin
    zone_next = zone_reg;
    case (zone_reg)
      ZONE_LOW: begin
        if (lvl32 >= LOW_LVL + HYST)
          zone_next = raw;
      end
      ZONE_MID: begin
        zone_next = raw;
      end
      ZONE_HEALTHY: begin
        if (raw == ZONE_FULL || lvl32 < HEALTHY_LVL - HYST)
          zone_next = raw;
      end
      ZONE_FULL: begin
        if (lvl32 < FULL_LVL - HYST)
          zone_next = raw;
      end
      default: zone_next = raw;
    endcase
  end

  // Saturating count of consecutive over-threshold samples.
  always_comb begin
    ov_cnt_next = ov_cnt_reg;
    if (sample_valid) begin
      if (32'(voltage) > V_MAX)
        ov_cnt_next = (ov_cnt_reg == CNT_MAX) ? ov_cnt_reg : ov_cnt_reg + 1'b1;
      else
        ov_cnt_next = '0;
    end
  end

  // The clear looks at the counter as it stands, so an ack only works once a
  // good sample has already been seen; set takes priority over clear.
  assign alert_set = sample_valid && (ov_cnt_next == CNT_MAX);
  assign alert_clr = ack_fault && (ov_cnt_reg == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      zone_reg          <= ZONE_MID;
      init_reg          <= 1'b1;
      pulse_low_reg     <= 1'b0;
      pulse_healthy_reg <= 1'b0;
      pulse_full_reg    <= 1'b0;
      ov_cnt_reg        <= '0;
      alert_reg         <= 1'b0;
    end else begin
      pulse_low_reg     <= 1'b0;
      pulse_healthy_reg <= 1'b0;
      pulse_full_reg    <= 1'b0;
      if (sample_valid) begin
        ov_cnt_reg <= ov_cnt_next;
        if (init_reg) begin
          // First sample loads the zone silently.
          zone_reg <= raw;
          init_reg <= 1'b0;
        end else begin
          zone_reg          <= zone_next;
          pulse_low_reg     <= (zone_next == ZONE_LOW) && (zone_reg != ZONE_LOW);
          pulse_healthy_reg <= (zone_next == ZONE_HEALTHY) &&
                               (zone_reg == ZONE_LOW || zone_reg == ZONE_MID);
          pulse_full_reg    <= (zone_next == ZONE_FULL) && (zone_reg != ZONE_FULL);
        end
      end
      if (alert_set)
        alert_reg <= 1'b1;
      else if (alert_clr)
        alert_reg <= 1'b0;
    end
  end

  assign pulse_low        = pulse_low_reg;
  assign pulse_healthy    = pulse_healthy_reg;
  assign pulse_full       = pulse_full_reg;
  assign overcharge_alert = alert_reg;
  assign in_full          = (zone_reg == ZONE_FULL);

endmodule

// File: rtl/multi_cell_health_monitor.sv
// Pack-level battery supervisor for N_CELLS cells.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   sample_valid      : level/voltage buses valid this cycle
//   level, voltage    : packed per-cell samples, cell i at [i*W +: W]
//   ack_fault         : request to clear latched overcharge alerts
//   pulse_low/healthy/full : per-cell one-cycle zone-entry pulses
//   overcharge_alert  : per-cell latched alerts
//   any_fault         : OR of the alerts (one cycle behind them)
//   fault_cell        : lowest alerting cell index, 0 when none
//   charge_en         : low while any cell is alerting or FULL
//   min_level         : minimum level of the last valid sample
module multi_cell_health_monitor
  import cell_mon_pkg::*;
#(
  parameter int unsigned N_CELLS     = 4,
  parameter int unsigned LVL_W       = 8,
  parameter int unsigned V_W         = 8,
  parameter int unsigned LOW_LVL     = 20,
  parameter int unsigned HEALTHY_LVL = 80,
  parameter int unsigned FULL_LVL    = 100,
  parameter int unsigned HYST        = 2,
  parameter int unsigned V_MAX       = 240,
  parameter int unsigned OV_PERSIST  = 4,
  localparam int unsigned FC_W       = (N_CELLS > 1) ? $clog2(N_CELLS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sample_valid,
  input  logic [N_CELLS*LVL_W-1:0] level,
  input  logic [N_CELLS*V_W-1:0]   voltage,
  input  logic                     ack_fault,
  output logic [N_CELLS-1:0]       pulse_low,
  output logic [N_CELLS-1:0]       pulse_healthy,
  output logic [N_CELLS-1:0]       pulse_full,
  output logic [N_CELLS-1:0]       overcharge_alert,
  output logic                     any_fault,
  output logic [FC_W-1:0]          fault_cell,
  output logic                     charge_en,
  output logic [LVL_W-1:0]         min_level
);

  logic [N_CELLS-1:0] alert_w;
  logic [N_CELLS-1:0] full_w;
  logic [FC_W-1:0]    fault_cell_next;
  logic [LVL_W-1:0]   min_level_next;
  logic               any_fault_reg;
  logic [FC_W-1:0]    fault_cell_reg;
  logic               charge_en_reg;
  logic [LVL_W-1:0]   min_level_reg;

  for (genvar gi = 0; gi < N_CELLS; gi++) begin : g_cell
    cell_zone_tracker #(
      .LVL_W      (LVL_W),
      .V_W        (V_W),
      .LOW_LVL    (LOW_LVL),
      .HEALTHY_LVL(HEALTHY_LVL),
      .FULL_LVL   (FULL_LVL),
      .HYST       (HYST),
      .V_MAX      (V_MAX),
      .OV_PERSIST (OV_PERSIST)
    ) u_tracker (
      .clk             (clk),
      .reset           (reset),
      .sample_valid    (sample_valid),
      .level           (level[gi*LVL_W +: LVL_W]),
      .voltage         (voltage[gi*V_W +: V_W]),
      .ack_fault       (ack_fault),
      .pulse_low       (pulse_low[gi]),
      .pulse_healthy   (pulse_healthy[gi]),
      .pulse_full      (pulse_full[gi]),
      .overcharge_alert(alert_w[gi]),
      .in_full         (full_w[gi])
    );
  end

  // Scan downward so the lowest alerting index is the last one written.
  always_comb begin
    fault_cell_next = '0;
    for (int i = N_CELLS - 1; i >= 0; i--) begin
      if (alert_w[i])
        fault_cell_next = FC_W'(i);
    end
  end

  always_comb begin
    min_level_next = level[LVL_W-1:0];
    for (int i = 1; i < N_CELLS; i++) begin
      if (level[i*LVL_W +: LVL_W] < min_level_next)
        min_level_next = level[i*LVL_W +: LVL_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      any_fault_reg  <= 1'b0;
      fault_cell_reg <= '0;
      charge_en_reg  <= 1'b1;
      min_level_reg  <= '0;
    end else begin
      any_fault_reg  <= |alert_w;
      fault_cell_reg <= fault_cell_next;
      charge_en_reg  <= !((|alert_w) || (|full_w));
      if (sample_valid)
        min_level_reg <= min_level_next;
    end
  end

  assign overcharge_alert = alert_w;
  assign any_fault        = any_fault_reg;
  assign fault_cell       = fault_cell_reg;
  assign charge_en        = charge_en_reg;
  assign min_level        = min_level_reg;

endmodule

// File: tb/tb_multi_cell_health_monitor.sv
// Directed bench for multi_cell_health_monitor with a rule-level model
// compared on every falling edge, plus literal spot checks.
module tb_multi_cell_health_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_valid;
  logic [31:0] level;
  logic [31:0] voltage;
  logic        ack_fault;
  logic [3:0]  pulse_low, pulse_healthy, pulse_full, overcharge_alert;
  logic        any_fault;
  logic [1:0]  fault_cell;
  logic        charge_en;
  logic [7:0]  min_level;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multi_cell_health_monitor dut (
    .clk             (clk),
    .reset           (reset),
    .sample_valid    (sample_valid),
    .level           (level),
    .voltage         (voltage),
    .ack_fault       (ack_fault),
    .pulse_low       (pulse_low),
    .pulse_healthy   (pulse_healthy),
    .pulse_full      (pulse_full),
    .overcharge_alert(overcharge_alert),
    .any_fault       (any_fault),
    .fault_cell      (fault_cell),
    .charge_en       (charge_en),
    .min_level       (min_level)
  );

  // ---------------- behavioural model ----------------
  // Zones as numbers 0=LOW 1=MID 2=HEALTHY 3=FULL.
  int         m_zone[4];
  int         m_cnt[4];
  logic [3:0] m_alert, m_pl, m_ph, m_pf;
  logic       m_init, m_any, m_ce;
  logic       m_ready = 1'b0;
  logic [1:0] m_fc;
  logic [7:0] m_min;

  always @(posedge clk) begin : model
    int lvl, vlt, raw, nz, oc, mn;
    logic any_full;
    if (reset) begin
      for (int c = 0; c < 4; c++) begin
        m_zone[c] = 1;
        m_cnt[c]  = 0;
      end
      m_alert = 0; m_pl = 0; m_ph = 0; m_pf = 0;
      m_init = 1; m_any = 0; m_fc = 0; m_ce = 1; m_min = 0;
      m_ready = 1;
    end else begin
      // pack flags lag the per-cell state by one cycle
      any_full = 0;
      for (int c = 0; c < 4; c++)
        if (m_zone[c] == 3) any_full = 1;
      m_any = |m_alert;
      m_fc = 0;
      for (int c = 3; c >= 0; c--)
        if (m_alert[c]) m_fc = 2'(c);
      m_ce = !(m_any || any_full);
      m_pl = 0; m_ph = 0; m_pf = 0;
      for (int c = 0; c < 4; c++) begin
        oc = m_cnt[c];
        if (sample_valid) begin
          lvl = int'(level[c*8 +: 8]);
          vlt = int'(voltage[c*8 +: 8]);
          raw = (lvl <= 20) ? 0 : (lvl >= 100) ? 3 : (lvl >= 80) ? 2 : 1;
          if (m_init) begin
            m_zone[c] = raw;
          end else begin
            nz = m_zone[c];
            if (raw > nz) begin
              if (!(nz == 0 && lvl < 22)) nz = raw;
            end else if (raw < nz) begin
              if ((nz == 3 && lvl < 98) || (nz == 2 && lvl < 78) || nz == 1) nz = raw;
            end
            if (nz != m_zone[c]) begin
              m_pl[c] = (nz == 0);
              m_ph[c] = (nz == 2) && (nz > m_zone[c]);
              m_pf[c] = (nz == 3);
            end
            m_zone[c] = nz;
          end
          m_cnt[c] = (vlt > 240) ? ((oc < 4) ? oc + 1 : 4) : 0;
        end
        if (sample_valid && m_cnt[c] == 4) m_alert[c] = 1;
        else if (ack_fault && oc == 0)     m_alert[c] = 0;
      end
      if (sample_valid) begin
        m_init = 0;
        mn = 255;
        for (int c = 0; c < 4; c++)
          if (int'(level[c*8 +: 8]) < mn) mn = int'(level[c*8 +: 8]);
        m_min = 8'(mn);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_ready) begin
      cmp("m_pulse_low", 32'(pulse_low), 32'(m_pl));
      cmp("m_pulse_healthy", 32'(pulse_healthy), 32'(m_ph));
      cmp("m_pulse_full", 32'(pulse_full), 32'(m_pf));
      cmp("m_alert", 32'(overcharge_alert), 32'(m_alert));
      cmp("m_any_fault", 32'(any_fault), 32'(m_any));
      cmp("m_fault_cell", 32'(fault_cell), 32'(m_fc));
      cmp("m_charge_en", 32'(charge_en), 32'(m_ce));
      cmp("m_min_level", 32'(min_level), 32'(m_min));
    end
  end

  // ---------------- stimulus ----------------
  int lv[4];
  int vv[4];

  task automatic samp();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      level[i*8 +: 8]   = lv[i][7:0];
      voltage[i*8 +: 8] = vv[i][7:0];
    end
    sample_valid = 1'b1;
    ack_fault    = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    sample_valid = 1'b0;
    ack_fault    = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic ack_cycle();
    @(negedge clk);
    sample_valid = 1'b0;
    ack_fault    = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    cmp({tag, "_pulses"}, 32'({pulse_low, pulse_healthy, pulse_full}), 32'd0);
    cmp({tag, "_alert"}, 32'(overcharge_alert), 32'd0);
    cmp({tag, "_any_fault"}, 32'(any_fault), 32'd0);
    cmp({tag, "_fault_cell"}, 32'(fault_cell), 32'd0);
    cmp({tag, "_charge_en"}, 32'(charge_en), 32'd1);
    cmp({tag, "_min_level"}, 32'(min_level), 32'd0);
  endtask

  initial begin
    reset = 1'b1; sample_valid = 1'b0; ack_fault = 1'b0;
    level = '0; voltage = '0;
    for (int i = 0; i < 4; i++) vv[i] = 200;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    reset = 1'b0;

    // first sample: silent load, then MID->HEALTHY on cell0
    lv[0] = 50; lv[1] = 80; lv[2] = 100; lv[3] = 100;
    samp();
    cmp("first_no_pulse", 32'({pulse_low, pulse_healthy, pulse_full}), 32'd0);
    cmp("first_min", 32'(min_level), 32'd50);
    lv[0] = 79; samp();
    lv[0] = 80; samp();
    cmp("c0_healthy_pulse", 32'(pulse_healthy), 32'h1);
    idle();
    cmp("pulse_clears", 32'(pulse_healthy), 32'h0);

    // cell1 HEALTHY hysteresis, then LOW
    lv[1] = 79; samp();
    lv[1] = 77; samp();
    cmp("c1_to_mid_no_pulse", 32'({pulse_low, pulse_healthy}), 32'h0);
    lv[1] = 20; samp();
    cmp("c1_low_pulse", 32'(pulse_low), 32'h2);
    cmp("min_20", 32'(min_level), 32'd20);

    // cell2 overvoltage persistence
    vv[2] = 241; samp(); samp(); samp();
    vv[2] = 239; samp();
    cmp("no_alert_3", 32'(overcharge_alert), 32'h0);
    vv[2] = 241; samp(); samp(); samp(); samp();
    cmp("c2_alert", 32'(overcharge_alert), 32'h4);
    idle();
    cmp("fault_cell_2", 32'(fault_cell), 32'd2);
    cmp("any_fault_1", 32'(any_fault), 32'd1);
    cmp("charge_en_0", 32'(charge_en), 32'd0);

    // ack ignored while still over-voltage, honoured after a good sample
    ack_cycle();
    cmp("ack_ignored", 32'(overcharge_alert), 32'h4);
    vv[2] = 230; samp();
    cmp("alert_holds", 32'(overcharge_alert), 32'h4);
    ack_cycle();
    cmp("ack_clears", 32'(overcharge_alert), 32'h0);
    idle();
    cmp("ce_still_0_full", 32'(charge_en), 32'd0);

    // cell3 FULL hysteresis; cell2 leaves FULL
    lv[2] = 90; lv[3] = 98; samp();
    cmp("c3_98_stays", 32'({pulse_healthy, pulse_full}), 32'h0);
    lv[3] = 97; samp();
    cmp("c3_97_no_pulse", 32'(pulse_healthy), 32'h0);
    idle();
    cmp("ce_back_1", 32'(charge_en), 32'd1);

    // multi-zone jumps
    lv[0] = 10; samp();
    cmp("c0_low", 32'(pulse_low), 32'h1);
    lv[0] = 100; samp();
    cmp("c0_jump_full", 32'({pulse_low, pulse_healthy, pulse_full}), 32'h001);

    // LOW exit hysteresis and level above 100
    lv[1] = 21; samp();
    cmp("c1_21_stays_low", 32'({pulse_low, pulse_healthy}), 32'h0);
    lv[1] = 22; samp();
    lv[1] = 85; lv[3] = 120; samp();
    cmp("c1_healthy", 32'(pulse_healthy), 32'h2);
    cmp("c3_120_full", 32'(pulse_full), 32'h8);

    // two alerts -> lowest index reported, then reset mid-alert
    vv[1] = 250; vv[3] = 250; samp(); samp(); samp(); samp();
    cmp("alert_1010", 32'(overcharge_alert), 32'ha);
    idle();
    cmp("fault_cell_1", 32'(fault_cell), 32'd1);
    @(negedge clk);
    reset = 1'b1; sample_valid = 1'b0;
    @(posedge clk);
    #1;
    check_reset_values("midreset");
    @(negedge clk);
    reset = 1'b0;

    // silent re-init after reset
    for (int i = 0; i < 4; i++) vv[i] = 200;
    lv[0] = 10; lv[1] = 50; lv[2] = 90; lv[3] = 100;
    samp();
    cmp("reinit_no_pulse", 32'({pulse_low, pulse_healthy, pulse_full}), 32'h0);
    lv[0] = 50; samp();
    cmp("low_exit_no_pulse", 32'({pulse_low, pulse_healthy, pulse_full}), 32'h0);
    idle();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
